// File: rtl/pitch_glide_ctrl_pkg.sv
// Shared types and constants for the pitch glide engine.
package synth_glide_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    ALWAYS = 2'd1,
    LEGATO = 2'd2
  } glide_mode_e;

  localparam logic [6:0] GLIDE_STEP_ADR = 7'h10;
  localparam logic [6:0] GLIDE_MODE_ADR = 7'h11;

  typedef logic [0:0] fsm_state_t;
  localparam fsm_state_t ST_IDLE  = 1'b0;
  localparam fsm_state_t ST_SWEEP = 1'b1;

  // A note on lands directly on its target unless a glide is actually wanted.
  // Mode code 3 matches neither ALWAYS nor LEGATO, so it behaves as OFF.
  function automatic logic glide_snap(input logic [1:0] mode,
                                      input logic [7:0] step,
                                      input logic       any_held);
    logic gliding;
    gliding    = (mode == ALWAYS) || (mode == LEGATO);
    glide_snap = !gliding || (step == 8'h00) || ((mode == LEGATO) && !any_held);
  endfunction

endpackage

// File: rtl/pitch_glide_ctrl_if.sv
// Key, register and result-stream signals of the glide engine.
interface pitch_glide_ctrl_if #(
  parameter int unsigned VOICES  = 8,
  parameter int unsigned V_WIDTH = 3,
  parameter int unsigned KEY_W   = 8,
  parameter int unsigned FRAC_W  = 8
);
  logic                    key_event;
  logic                    key_gate;
  logic [V_WIDTH-1:0]      cur_key_adr;
  logic [KEY_W-1:0]        cur_key_val;
  logic                    step_en;
  logic                    com_sel;
  logic                    write;
  logic                    read;
  logic [6:0]              adr;
  logic [7:0]              synth_data_in;
  logic [7:0]              synth_data_out;
  logic                    out_valid;
  logic [V_WIDTH-1:0]      out_vx;
  logic [KEY_W+FRAC_W-1:0] out_pitch;
  logic [VOICES-1:0]       glide_busy;
  logic                    sweep_overrun;

  modport master (
    output key_event, key_gate, cur_key_adr, cur_key_val, step_en,
           com_sel, write, read, adr, synth_data_in,
    input  synth_data_out, out_valid, out_vx, out_pitch, glide_busy, sweep_overrun
  );

  modport slave (
    input  key_event, key_gate, cur_key_adr, cur_key_val, step_en,
           com_sel, write, read, adr, synth_data_in,
    output synth_data_out, out_valid, out_vx, out_pitch, glide_busy, sweep_overrun
  );
endinterface

// File: rtl/pitch_glide_ctrl_slew.sv
// One-voice slew ALU: moves cur toward tgt by step, clamping on arrival.
module glide_slew #(
  parameter int unsigned P_W    = 16,
  parameter int unsigned STEP_W = 8
) (
  input  logic [P_W-1:0]    cur,
  input  logic [P_W-1:0]    tgt,
  input  logic [STEP_W-1:0] step,
  output logic [P_W-1:0]    next
);
  logic signed [P_W:0] d;
  logic signed [P_W:0] mag;
  logic signed [P_W:0] step_x;

  // Signed distance, then either land on target or take one step toward it.
  always_comb begin
    d      = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag    = d[P_W] ? -d : d;
    step_x = $signed({{(P_W + 1 - STEP_W){1'b0}}, step});
    if (mag <= step_x)
      next = tgt;
    else if (d[P_W])
      next = cur - P_W'(step);
    else
      next = cur + P_W'(step);
  end
endmodule

// File: rtl/pitch_glide_ctrl.sv
// Per-voice portamento engine: time-multiplexed slew of current pitch to target.
module pitch_glide_ctrl
  import synth_glide_pkg::*;
#(
  parameter int unsigned VOICES  = 8,
  parameter int unsigned V_WIDTH = 3,
  parameter int unsigned KEY_W   = 8,
  parameter int unsigned FRAC_W  = 8
) (
  input  logic             sCLK_XVXOSC,
  input  logic             reset_reg,
  pitch_glide_ctrl_if.slave bus
);
  localparam int unsigned P_W = KEY_W + FRAC_W;

  logic [P_W-1:0]     cur [VOICES];
  logic [P_W-1:0]     tgt [VOICES];
  logic [VOICES-1:0]  held;
  logic [7:0]         glide_step;
  logic [1:0]         glide_mode;
  logic [7:0]         rd_data;

  fsm_state_t         state;
  logic [V_WIDTH-1:0] vcnt;
  logic               out_valid_r;
  logic [V_WIDTH-1:0] out_vx_r;
  logic [P_W-1:0]     out_pitch_r;
  logic               overrun_r;
  logic [VOICES-1:0]  busy;

  logic               sweeping;
  logic               note_on;
  logic               snap;
  logic               hit;
  logic [P_W-1:0]     ev_pitch;
  logic [P_W-1:0]     slew_next;
  logic [P_W-1:0]     stream_pitch;

  assign sweeping = (state == ST_SWEEP);
  assign note_on  = bus.key_event && bus.key_gate;
  assign ev_pitch = {bus.cur_key_val, {FRAC_W{1'b0}}};
  assign snap     = glide_snap(glide_mode, glide_step, |held);
  assign hit      = sweeping && note_on && (bus.cur_key_adr == vcnt);

  glide_slew #(.P_W(P_W), .STEP_W(8)) u_slew (
    .cur  (cur[vcnt]),
    .tgt  (tgt[vcnt]),
    .step (glide_step),
    .next (slew_next)
  );

  // A note on to the voice being swept overrides its slew; the stream shows the event result.
  assign stream_pitch = hit ? (snap ? ev_pitch : cur[vcnt]) : slew_next;

  // Register block: glide step/mode writes and registered readback.
  always_ff @(posedge sCLK_XVXOSC or posedge reset_reg) begin
    if (reset_reg) begin
      glide_step <= '0;
      glide_mode <= OFF;
      rd_data    <= '0;
    end else begin
      if (bus.com_sel && bus.write) begin
        if (bus.adr == GLIDE_STEP_ADR) glide_step <= bus.synth_data_in;
        if (bus.adr == GLIDE_MODE_ADR) glide_mode <= bus.synth_data_in[1:0];
      end
      if (bus.com_sel && bus.read) begin
        case (bus.adr)
          GLIDE_STEP_ADR: rd_data <= glide_step;
          GLIDE_MODE_ADR: rd_data <= {6'b0, glide_mode};
          default:        rd_data <= '0;
        endcase
      end
    end
  end

  // Sweep sequencer and result stream register.
  always_ff @(posedge sCLK_XVXOSC or posedge reset_reg) begin
    if (reset_reg) begin
      state       <= ST_IDLE;
      vcnt        <= '0;
      out_valid_r <= 1'b0;
      out_vx_r    <= '0;
      out_pitch_r <= '0;
      overrun_r   <= 1'b0;
    end else begin
      overrun_r <= sweeping && bus.step_en;
      if (sweeping) begin
        out_valid_r <= 1'b1;
        out_vx_r    <= vcnt;
        out_pitch_r <= stream_pitch;
        vcnt        <= vcnt + 1'b1;
        if (vcnt == V_WIDTH'(VOICES - 1)) state <= ST_IDLE;
      end else begin
        out_valid_r <= 1'b0;
        if (bus.step_en) begin
          state <= ST_SWEEP;
          vcnt  <= '0;
        end
      end
    end
  end

  // Voice state: key events take priority over the sweep write on the same voice.
  always_ff @(posedge sCLK_XVXOSC or posedge reset_reg) begin
    if (reset_reg) begin
      for (int unsigned i = 0; i < VOICES; i++) begin
        cur[i] <= '0;
        tgt[i] <= '0;
      end
      held <= '0;
    end else begin
      for (int unsigned i = 0; i < VOICES; i++) begin
        if (note_on && (bus.cur_key_adr == V_WIDTH'(i))) begin
          tgt[i] <= ev_pitch;
          if (snap) cur[i] <= ev_pitch;
        end else if (sweeping && (vcnt == V_WIDTH'(i))) begin
          cur[i] <= slew_next;
        end
        if (bus.key_event && (bus.cur_key_adr == V_WIDTH'(i)))
          held[i] <= bus.key_gate;
      end
    end
  end

  // Busy flags follow the stored pitch directly.
  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < VOICES; i++)
      busy[i] = (cur[i] != tgt[i]);
  end

  assign bus.synth_data_out = rd_data;
  assign bus.out_valid      = out_valid_r;
  assign bus.out_vx         = out_vx_r;
  assign bus.out_pitch      = out_pitch_r;
  assign bus.glide_busy     = busy;
  assign bus.sweep_overrun  = overrun_r;
endmodule

// File: tb/tb_pitch_glide_ctrl.sv
// Scoreboard bench for pitch_glide_ctrl with directed, hand-computed sweeps.
module tb_pitch_glide_ctrl;
  import synth_glide_pkg::*;

  typedef struct {
    logic [2:0]  vx;
    logic [15:0] pitch;
  } exp_t;

  logic sCLK_XVXOSC = 1'b0;
  logic reset_reg   = 1'b1;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  int          overrun_cnt = 0;
  logic [15:0] ep [8];

  always #5 sCLK_XVXOSC = ~sCLK_XVXOSC;

  pitch_glide_ctrl_if #(.VOICES(8), .V_WIDTH(3), .KEY_W(8), .FRAC_W(8)) bus ();

  pitch_glide_ctrl #(.VOICES(8), .V_WIDTH(3), .KEY_W(8), .FRAC_W(8)) dut (
    .sCLK_XVXOSC (sCLK_XVXOSC),
    .reset_reg   (reset_reg),
    .bus         (bus)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
    end
  endtask

  // Monitor: pop one expectation per streamed result.
  always @(negedge sCLK_XVXOSC) begin
    if (!reset_reg) begin
      if (bus.sweep_overrun === 1'b1) overrun_cnt++;
      if (bus.out_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid got vx=%0d pitch=0x%0h want no output", bus.out_vx, bus.out_pitch);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check($sformatf("stream_vx(exp v%0d)", e.vx), 32'(bus.out_vx), 32'(e.vx));
          check($sformatf("stream_pitch_v%0d", e.vx), 32'(bus.out_pitch), 32'(e.pitch));
        end
      end
    end
  end

  task automatic tick;
    @(posedge sCLK_XVXOSC);
    #1;
  endtask

  task automatic key(input logic [2:0] v, input logic gate, input logic [7:0] val);
    bus.key_event = 1'b1; bus.key_gate = gate; bus.cur_key_adr = v; bus.cur_key_val = val;
    tick;
    bus.key_event = 1'b0;
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    bus.com_sel = 1'b1; bus.write = 1'b1; bus.adr = a; bus.synth_data_in = d;
    tick;
    bus.com_sel = 1'b0; bus.write = 1'b0;
  endtask

  task automatic rd(input logic [6:0] a, input logic [7:0] want, input string name);
    bus.com_sel = 1'b1; bus.read = 1'b1; bus.adr = a;
    tick;
    bus.com_sel = 1'b0; bus.read = 1'b0;
    check(name, 32'(bus.synth_data_out), 32'(want));
  endtask

  task automatic push_sweep;
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      e.vx = 3'(i);
      e.pitch = ep[i];
      sb_q.push_back(e);
    end
  endtask

  // Sweep with optional collision (note on v5 key 0x30) and overrun step_en at given cycles.
  task automatic sweep_ex(input int collide_at, input int ovr_at, input int want_ovr);
    overrun_cnt = 0;
    push_sweep();
    bus.step_en = 1'b1;
    tick;
    bus.step_en = 1'b0;
    bus.cur_key_adr = 3'd5; bus.cur_key_val = 8'h30; bus.key_gate = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      tick;
      bus.key_event = (c == collide_at);
      bus.step_en   = (c == ovr_at);
    end
    check("sweep_drain", 32'(sb_q.size()), 32'd0);
    check("sweep_overrun_count", 32'(overrun_cnt), 32'(want_ovr));
  endtask

  task automatic sweep;
    sweep_ex(-1, -1, 0);
  endtask

  initial begin
    logic [15:0] clamp_seq [7];
    clamp_seq[0] = 16'h3DD0; clamp_seq[1] = 16'h3DA0; clamp_seq[2] = 16'h3D70;
    clamp_seq[3] = 16'h3D40; clamp_seq[4] = 16'h3D10; clamp_seq[5] = 16'h3D00;
    clamp_seq[6] = 16'h3D00;
    for (int i = 0; i < 8; i++) ep[i] = 16'h0000;
    bus.key_event = 0; bus.key_gate = 0; bus.cur_key_adr = 0; bus.cur_key_val = 0;
    bus.step_en = 0; bus.com_sel = 0; bus.write = 0; bus.read = 0; bus.adr = 0;
    bus.synth_data_in = 0;

    // Reset state
    repeat (3) tick;
    reset_reg = 1'b0;
    tick;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_busy", 32'(bus.glide_busy), 32'd0);
    check("reset_overrun", 32'(bus.sweep_overrun), 32'd0);
    check("reset_pitch", 32'(bus.out_pitch), 32'd0);
    rd(GLIDE_STEP_ADR, 8'h00, "reset_step_rd");
    rd(GLIDE_MODE_ADR, 8'h00, "reset_mode_rd");

    // OFF mode snaps
    key(3'd2, 1'b1, 8'd60);
    ep[2] = 16'h3C00;
    check("off_busy", 32'(bus.glide_busy), 32'd0);
    sweep();

    // ALWAYS, step 0x80, v0 3C00 -> 3E00
    key(3'd0, 1'b1, 8'd60);
    ep[0] = 16'h3C00;
    wr(GLIDE_STEP_ADR, 8'h80);
    wr(GLIDE_MODE_ADR, 8'h01);
    rd(GLIDE_STEP_ADR, 8'h80, "step_rd");
    rd(GLIDE_MODE_ADR, 8'h01, "mode_rd");
    rd(7'h12, 8'h00, "other_adr_rd");
    key(3'd0, 1'b1, 8'd62);
    check("always_busy_start", 32'(bus.glide_busy), 32'h01);
    ep[0] = 16'h3C80; sweep();
    ep[0] = 16'h3D00; sweep();
    ep[0] = 16'h3D80; sweep();
    check("always_busy_sweep3", 32'(bus.glide_busy), 32'h01);
    ep[0] = 16'h3E00; sweep();
    check("always_busy_done", 32'(bus.glide_busy), 32'h00);
    sweep();

    // Clamp down, step 0x30
    wr(GLIDE_MODE_ADR, 8'h00);
    key(3'd1, 1'b1, 8'h3E);
    ep[1] = 16'h3E00;
    wr(GLIDE_STEP_ADR, 8'h30);
    wr(GLIDE_MODE_ADR, 8'h01);
    key(3'd1, 1'b1, 8'h3D);
    check("clamp_busy_start", 32'(bus.glide_busy), 32'h02);
    for (int s = 0; s < 7; s++) begin
      ep[1] = clamp_seq[s];
      sweep();
    end
    check("clamp_busy_done", 32'(bus.glide_busy), 32'h00);

    // LEGATO
    for (int v = 0; v < 8; v++) key(3'(v), 1'b0, 8'h00);
    wr(GLIDE_MODE_ADR, 8'h02);
    key(3'd3, 1'b1, 8'h40);
    ep[3] = 16'h4000;
    check("legato_first_snap", 32'(bus.glide_busy), 32'h00);
    key(3'd4, 1'b1, 8'h42);
    check("legato_held_glides", 32'(bus.glide_busy), 32'h10);
    ep[4] = 16'h0030;
    sweep();
    key(3'd3, 1'b0, 8'h00);
    key(3'd4, 1'b0, 8'h00);
    key(3'd3, 1'b1, 8'h45);
    ep[3] = 16'h4500;
    check("legato_resnap", 32'(bus.glide_busy), 32'h10);
    wr(GLIDE_MODE_ADR, 8'h00);
    key(3'd4, 1'b1, 8'h42);
    ep[4] = 16'h4200;
    key(3'd4, 1'b0, 8'h00);
    sweep();

    // Collision and overrun
    wr(GLIDE_STEP_ADR, 8'h10);
    wr(GLIDE_MODE_ADR, 8'h01);
    key(3'd5, 1'b1, 8'h20);
    check("collide_busy", 32'(bus.glide_busy), 32'h20);
    ep[5] = 16'h0000;
    sweep_ex(5, -1, 0);
    ep[5] = 16'h0010;
    sweep_ex(-1, 3, 1);
    check("overrun_busy", 32'(bus.glide_busy), 32'h20);

    // Reset mid-sweep
    ep[5] = 16'h0020;
    push_sweep();
    bus.step_en = 1'b1;
    tick;
    bus.step_en = 1'b0;
    repeat (3) tick;
    #1 reset_reg = 1'b1;
    sb_q.delete();
    tick;
    check("midreset_out_valid", 32'(bus.out_valid), 32'd0);
    check("midreset_busy", 32'(bus.glide_busy), 32'd0);
    check("midreset_vx", 32'(bus.out_vx), 32'd0);
    reset_reg = 1'b0;
    tick;
    rd(GLIDE_STEP_ADR, 8'h00, "midreset_step_rd");
    rd(GLIDE_MODE_ADR, 8'h00, "midreset_mode_rd");
    for (int i = 0; i < 8; i++) ep[i] = 16'h0000;
    sweep();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
